// File: rtl/instr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_buffer
// Description : Circular instruction queue between fetch and dispatch.
//               Accepts up to N instructions per cycle (all-or-nothing),
//               presents the oldest up to N in program order, retires the
//               number dispatch reports (clamped), and empties on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_buffer #(
    parameter int N      = 3,
    parameter int DEPTH  = 8,
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int CNT_W  = $clog2(N + 1),
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N*INST_W-1:0] in_inst,
    input  logic [N*PC_W-1:0]   in_pc,
    input  logic [N-1:0]        in_pred_taken,
    input  logic [CNT_W-1:0]    in_count,
    output logic                in_accept,
    output logic [CNT_W-1:0]    spots,
    output logic [N*INST_W-1:0] out_inst,
    output logic [N*PC_W-1:0]   out_pc,
    output logic [N-1:0]        out_pred_taken,
    output logic [CNT_W-1:0]    out_count,
    input  logic [CNT_W-1:0]    num_dispatched,
    input  logic                flush,
    output logic [OCC_W-1:0]    occupancy
);

    localparam int            PTR_W   = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] c_depth = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] c_n_occ = OCC_W'(N);

    // Storage array (never cleared; validity is tracked by the pointers)
    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic              r_mem_pt   [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_count;

    logic [OCC_W-1:0]  w_free;
    logic [CNT_W-1:0]  w_enq;
    logic [CNT_W-1:0]  w_deq;

    // Free space is judged on the current count only; same-cycle dequeues
    // do not make room for the incoming packet.
    assign w_free    = c_depth - r_count;
    assign in_accept = (OCC_W'(in_count) <= w_free) && !flush && !reset;
    assign spots     = (w_free > c_n_occ)  ? CNT_W'(N) : CNT_W'(w_free);
    assign out_count = (r_count > c_n_occ) ? CNT_W'(N) : CNT_W'(r_count);
    assign occupancy = r_count;

    assign w_enq = in_accept ? in_count : '0;
    // Over-reports from dispatch are clamped to what is actually visible
    assign w_deq = (num_dispatched > out_count) ? out_count : num_dispatched;

    // Output window: lane i reads entry (head+i) mod DEPTH, zero beyond out_count
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out_lane
            logic [PTR_W-1:0] w_idx;
            logic             w_valid;
            assign w_idx   = r_head + PTR_W'(gi);
            assign w_valid = (CNT_W'(gi) < out_count);
            assign out_inst[gi*INST_W +: INST_W] = w_valid ? r_mem_inst[w_idx] : '0;
            assign out_pc[gi*PC_W +: PC_W]       = w_valid ? r_mem_pc[w_idx]   : '0;
            assign out_pred_taken[gi]            = w_valid & r_mem_pt[w_idx];
        end
    endgenerate

    // Pointer and occupancy update; reset and flush both empty the queue
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PTR_W'(w_enq);
            r_head  <= r_head + PTR_W'(w_deq);
            r_count <= r_count + OCC_W'(w_enq) - OCC_W'(w_deq);
        end
    end

    // Write accepted lanes at consecutive slots from tail (gated by in_accept)
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) < w_enq) begin
                r_mem_inst[r_tail + PTR_W'(i)] <= in_inst[i*INST_W +: INST_W];
                r_mem_pc[r_tail + PTR_W'(i)]   <= in_pc[i*PC_W +: PC_W];
                r_mem_pt[r_tail + PTR_W'(i)]   <= in_pred_taken[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_buffer
// Description : Self-checking bench for instr_buffer against a queue-based
//               reference model; directed scenarios then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_buffer;

    localparam int N      = 3;
    localparam int DEPTH  = 8;
    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int OCC_W  = $clog2(DEPTH + 1);

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              pt;
    } entry_t;

    logic                clock = 1'b0;
    logic                reset;
    logic [N*INST_W-1:0] in_inst;
    logic [N*PC_W-1:0]   in_pc;
    logic [N-1:0]        in_pred_taken;
    logic [CNT_W-1:0]    in_count;
    logic                in_accept;
    logic [CNT_W-1:0]    spots;
    logic [N*INST_W-1:0] out_inst;
    logic [N*PC_W-1:0]   out_pc;
    logic [N-1:0]        out_pred_taken;
    logic [CNT_W-1:0]    out_count;
    logic [CNT_W-1:0]    num_dispatched;
    logic                flush;
    logic [OCC_W-1:0]    occupancy;

    int     checks = 0;
    int     errors = 0;
    entry_t model_q[$];
    int     next_pc = 0;

    instr_buffer #(.N(N), .DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_pred_taken  (in_pred_taken),
        .in_count       (in_count),
        .in_accept      (in_accept),
        .spots          (spots),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .out_count      (out_count),
        .num_dispatched (num_dispatched),
        .flush          (flush),
        .occupancy      (occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Compare every visible output against the model queue
    task automatic check_outputs();
        logic [N*INST_W-1:0] e_inst;
        logic [N*PC_W-1:0]   e_pc;
        logic [N-1:0]        e_pt;
        int                  vis;
        vis    = min2(model_q.size(), N);
        e_inst = '0;
        e_pc   = '0;
        e_pt   = '0;
        for (int i = 0; i < vis; i++) begin
            e_inst[i*INST_W +: INST_W] = model_q[i].inst;
            e_pc[i*PC_W +: PC_W]       = model_q[i].pc;
            e_pt[i]                    = model_q[i].pt;
        end
        chk("occupancy", 128'(occupancy), 128'(model_q.size()));
        chk("out_count", 128'(out_count), 128'(vis));
        chk("spots",     128'(spots),     128'(min2(DEPTH - model_q.size(), N)));
        chk("out_inst",  128'(out_inst),  128'(e_inst));
        chk("out_pc",    128'(out_pc),    128'(e_pc));
        chk("out_pt",    128'(out_pred_taken), 128'(e_pt));
    endtask

    // One clock cycle: drive inputs, check in_accept, clock, update model, check state
    task automatic step(input int cnt, input int nd, input bit fl, input bit rs);
        bit exp_acc;
        int deq;
        reset          = rs;
        flush          = fl;
        in_count       = CNT_W'(cnt);
        num_dispatched = CNT_W'(nd);
        for (int i = 0; i < N; i++) begin
            in_inst[i*INST_W +: INST_W] = $urandom;
            in_pc[i*PC_W +: PC_W]       = PC_W'(next_pc + 4 * i);
            in_pred_taken[i]            = 1'($urandom_range(0, 1));
        end
        #1;
        exp_acc = (cnt <= DEPTH - model_q.size()) && !fl && !rs;
        chk("in_accept", 128'(in_accept), 128'(exp_acc));
        @(posedge clock);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            deq = min2(nd, min2(model_q.size(), N));
            for (int i = 0; i < deq; i++) void'(model_q.pop_front());
            if (exp_acc) begin
                for (int i = 0; i < cnt; i++) begin
                    entry_t e;
                    e.inst = in_inst[i*INST_W +: INST_W];
                    e.pc   = in_pc[i*PC_W +: PC_W];
                    e.pt   = in_pred_taken[i];
                    model_q.push_back(e);
                end
                next_pc += 4 * cnt;
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset held two cycles
        step(0, 0, 0, 1);
        step(3, 0, 0, 1);
        chk("rst_occ",   128'(occupancy), 128'(0));
        chk("rst_spots", 128'(spots),     128'(3));
        chk("rst_lanes", 128'(out_pc),    128'(0));

        // Fill and reject
        step(3, 0, 0, 0);
        chk("fill_occ3", 128'(occupancy), 128'(3));
        step(3, 0, 0, 0);
        chk("fill_occ6", 128'(occupancy), 128'(6));
        chk("fill_spots2", 128'(spots), 128'(2));
        step(3, 0, 0, 0);
        chk("reject_occ", 128'(occupancy), 128'(6));
        step(2, 0, 0, 0);
        chk("full_occ",   128'(occupancy), 128'(8));
        chk("full_spots", 128'(spots),     128'(0));

        // Partial dispatch on PCs 0x00..0x0C
        step(0, 0, 1, 0);
        next_pc = 0;
        step(3, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("pd_pc", 128'(out_pc), 128'({32'h0C, 32'h08, 32'h04}));
        chk("pd_occ", 128'(occupancy), 128'(3));

        // Wrap-around: reach head=6 with occupancy 5, then enqueue+dispatch 3
        step(0, 0, 1, 0);
        step(3, 0, 0, 0);
        step(3, 0, 0, 0);
        step(0, 3, 0, 0);
        step(2, 3, 0, 0);
        step(3, 0, 0, 0);
        chk("wrap_pre_occ", 128'(occupancy), 128'(5));
        step(3, 3, 0, 0);
        chk("wrap_occ", 128'(occupancy), 128'(5));
        step(0, 2, 0, 0);
        step(0, 0, 0, 0);

        // Flush priority at occupancy 6
        step(0, 0, 1, 0);
        step(3, 0, 0, 0);
        step(3, 0, 0, 0);
        step(3, 2, 1, 0);
        chk("flush_occ",   128'(occupancy), 128'(0));
        chk("flush_spots", 128'(spots),     128'(3));

        // Over-report clamp at occupancy 2, then verify pointers still agree
        step(2, 0, 0, 0);
        step(0, 3, 0, 0);
        chk("clamp_occ", 128'(occupancy), 128'(0));
        step(1, 0, 0, 0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, N), $urandom_range(0, N),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
